// File: rtl/dmem_sized_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_sized_ctrl
//   Behavioural data memory for the tartaruga MEM stage. It supports byte,
//   half and word loads and stores with sign or zero extension. Requests use
//   a valid/ready handshake, and the response latency is configurable. The
//   block detects misaligned accesses. A word store to the tohost address
//   latches a sticky halt and an exit code.
//
// Parameters
//   DEPTH        memory size in 32-bit words (power of two, >= 2)
//   LATENCY      cycles from request accept to rsp_valid_o (>= 1)
//   TOHOST_ADDR  MMIO exit address; an aligned word store here halts the block
//   SIM_FINISH   1: end the simulation on a tohost store, 0: only latch halt
//
// Ports
//   clk_i, rstn_i           clock (rising edge), asynchronous active-low reset
//   req_valid_i/req_ready_o request handshake; one request outstanding at most
//   we_i, size_i            store/load select, 00 byte / 01 half / 10 word
//   unsigned_i              loads: 1 zero-extend, 0 sign-extend
//   addr_i, data_wr_i       byte address, right-aligned store data
//   pc_i                    PC of the access, only used in exit messages
//   rsp_valid_o             one-cycle response pulse
//   data_rd_o, misaligned_o response data / fault flag, held between pulses
//   halted_o, exit_code_o   sticky halt and tohost store data
// ---------------------------------------------------------------------------
module dmem_sized_ctrl #(
  parameter int unsigned DEPTH       = 4096,
  parameter int unsigned LATENCY     = 1,
  parameter logic [31:0] TOHOST_ADDR = 32'h4000_0000,
  parameter bit          SIM_FINISH  = 1'b1
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_wr_i,
  input  logic [31:0] pc_i,
  output logic        rsp_valid_o,
  output logic [31:0] data_rd_o,
  output logic        misaligned_o,
  output logic        halted_o,
  output logic [31:0] exit_code_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (LATENCY > 32'd1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [31:0]   r_mem [DEPTH];
  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_req_data;
  logic          r_req_fault;
  logic [31:0]   r_rsp_data;
  logic          r_rsp_fault;
  logic          r_halted;
  logic [31:0]   r_exit_code;

  logic          w_accept;
  logic          w_fault;
  logic          w_tohost;
  logic          w_mem_we;
  logic          w_enter_resp;
  logic [AW-1:0] w_idx;
  logic [1:0]    w_lane;
  logic [31:0]   w_rd_word;
  logic [31:0]   w_wr_word;
  logic [31:0]   w_ld_data;
  logic [1:0]    w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;

  // Size 11 is never legal; halves need an even lane, words lane 0.
  function automatic logic f_misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lane[0];
      SZ_WORD: bad = |lane;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Shift the addressed lane(s) down to bit 0 and extend to 32 bits.
  function automatic logic [31:0] f_load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] lane, input logic uns);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {lane, 3'b000};
    case (size)
      SZ_BYTE: begin
        if (uns) begin
          res = {24'd0, sh[7:0]};
        end else begin
          res = {{24{sh[7]}}, sh[7:0]};
        end
      end
      SZ_HALF: begin
        if (uns) begin
          res = {16'd0, sh[15:0]};
        end else begin
          res = {{16{sh[15]}}, sh[15:0]};
        end
      end
      SZ_WORD: res = word;
      default: res = 32'd0;
    endcase
    return res;
  endfunction

  // Merge right-aligned store data into the addressed lanes of the old word.
  function automatic logic [31:0] f_store_merge(input logic [31:0] old, input logic [31:0] wdata,
                                                input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] m;
    m = old;
    case (size)
      SZ_BYTE: m[{lane, 3'b000} +: 8]      = wdata[7:0];
      SZ_HALF: m[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      SZ_WORD: m = wdata;
      default: m = old;
    endcase
    return m;
  endfunction

  assign req_ready_o  = (r_state == ST_IDLE) & ~r_halted;
  assign rsp_valid_o  = (r_state == ST_RESP);
  assign data_rd_o    = r_rsp_data;
  assign misaligned_o = r_rsp_fault;
  assign halted_o     = r_halted;
  assign exit_code_o  = r_exit_code;

  // Request decode: index, lane, fault, tohost detection and data paths
  always_comb begin
    w_idx     = addr_i[AW+1:2];
    w_lane    = addr_i[1:0];
    w_accept  = req_valid_i & req_ready_o;
    w_fault   = f_misaligned(size_i, w_lane);
    w_tohost  = we_i & (size_i == SZ_WORD) & (addr_i == TOHOST_ADDR) & ~w_fault;
    w_mem_we  = w_accept & we_i & ~w_fault & ~w_tohost;
    w_rd_word = r_mem[w_idx];
    w_wr_word = f_store_merge(w_rd_word, data_wr_i, size_i, w_lane);
    if (we_i | w_fault) begin
      w_ld_data = 32'd0;
    end else begin
      w_ld_data = f_load_extend(w_rd_word, size_i, w_lane, unsigned_i);
    end
  end

  // Next state; r_cnt holds the cycles left before the response cycle
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (LATENCY == 32'd1) begin
            w_state_nxt = ST_RESP;
          end else begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = CW'(LATENCY - 32'd1);
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (r_cnt == CW'(32'd1)) begin
          w_state_nxt = ST_RESP;
          w_cnt_nxt   = {CW{1'b0}};
        end else begin
          w_cnt_nxt = r_cnt - CW'(32'd1);
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = {CW{1'b0}};
      end
    endcase
    w_enter_resp = (w_state_nxt == ST_RESP) & (r_state != ST_RESP);
  end

  // FSM state and latency counter registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= {CW{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Memory array; stores commit at the accept edge
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= 32'd0;
      end
    end else if (w_mem_we) begin
      r_mem[w_idx] <= w_wr_word;
    end
  end

  // Request register: the already-extended load result captured at accept
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_req_data  <= 32'd0;
      r_req_fault <= 1'b0;
    end else if (w_accept) begin
      r_req_data  <= w_ld_data;
      r_req_fault <= w_fault;
    end
  end

  // Response outputs, loaded when entering RESP. With LATENCY 1 that edge
  // is the accept edge itself, so the live decode is used directly.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_rsp_data  <= 32'd0;
      r_rsp_fault <= 1'b0;
    end else if (w_enter_resp) begin
      if (r_state == ST_IDLE) begin
        r_rsp_data  <= w_ld_data;
        r_rsp_fault <= w_fault;
      end else begin
        r_rsp_data  <= r_req_data;
        r_rsp_fault <= r_req_fault;
      end
    end
  end

  // Sticky halt and exit code from the tohost store
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_halted    <= 1'b0;
      r_exit_code <= 32'd0;
    end else if (w_accept & w_tohost) begin
      r_halted    <= 1'b1;
      r_exit_code <= data_wr_i;
    end
  end

`ifndef SYNTHESIS
  // Simulation exit reporting for the tohost store
  always @(posedge clk_i) begin
    if (rstn_i && w_accept && w_tohost) begin
      if (data_wr_i == 32'd1) begin
        $display("Execution succeeded at PC 0x%08h", pc_i);
      end else if (data_wr_i == 32'd2) begin
        $display("Execution failed at PC 0x%08h", pc_i);
      end else begin
        $display("Error at PC 0x%08h (exit code 0x%08h)", pc_i, data_wr_i);
      end
      if (SIM_FINISH != 1'b0) begin
        $finish;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_sized_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dmem_sized_ctrl
//   Two instances of dmem_sized_ctrl share the request inputs:
//     u_a: DEPTH 16, LATENCY 1
//     u_b: DEPTH 64, LATENCY 3
//   A byte-array reference model predicts every response. The model also
//   predicts the exact response cycle, the ready profile, and halt/exit.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dmem_sized_ctrl;

  localparam int unsigned DEPTH_A = 16;
  localparam int unsigned LAT_A   = 1;
  localparam int unsigned DEPTH_B = 64;
  localparam int unsigned LAT_B   = 3;
  localparam logic [31:0] TOHOST  = 32'h4000_0000;
  localparam logic [1:0]  SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_X = 2'd3;

  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  req_valid;
  logic        we;
  logic [1:0]  size;
  logic        uns;
  logic [31:0] addr, wdata, pc;
  logic [1:0]  rdy, rspv, mis, halt;
  logic [31:0] rdat [2];
  logic [31:0] exitc [2];

  int checks = 0;
  int errors = 0;

  // reference model: flat little-endian byte memories plus halt state
  logic [7:0]  mem_a [4*DEPTH_A];
  logic [7:0]  mem_b [4*DEPTH_B];
  logic        halt_m [2];
  logic [31:0] exit_m [2];

  always #5 clk = ~clk;

  dmem_sized_ctrl #(.DEPTH(DEPTH_A), .LATENCY(LAT_A), .TOHOST_ADDR(TOHOST), .SIM_FINISH(1'b0)) u_a (
    .clk_i(clk), .rstn_i(rstn), .req_valid_i(req_valid[0]), .req_ready_o(rdy[0]),
    .we_i(we), .size_i(size), .unsigned_i(uns), .addr_i(addr), .data_wr_i(wdata), .pc_i(pc),
    .rsp_valid_o(rspv[0]), .data_rd_o(rdat[0]), .misaligned_o(mis[0]),
    .halted_o(halt[0]), .exit_code_o(exitc[0]));

  dmem_sized_ctrl #(.DEPTH(DEPTH_B), .LATENCY(LAT_B), .TOHOST_ADDR(TOHOST), .SIM_FINISH(1'b0)) u_b (
    .clk_i(clk), .rstn_i(rstn), .req_valid_i(req_valid[1]), .req_ready_o(rdy[1]),
    .we_i(we), .size_i(size), .unsigned_i(uns), .addr_i(addr), .data_wr_i(wdata), .pc_i(pc),
    .rsp_valid_o(rspv[1]), .data_rd_o(rdat[1]), .misaligned_o(mis[1]),
    .halted_o(halt[1]), .exit_code_o(exitc[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    foreach (mem_a[i]) mem_a[i] = 8'd0;
    foreach (mem_b[i]) mem_b[i] = 8'd0;
    halt_m[0] = 1'b0; halt_m[1] = 1'b0;
    exit_m[0] = 32'd0; exit_m[1] = 32'd0;
  endtask

  function automatic logic [7:0] get_byte(input int sel, input logic [31:0] a);
    int unsigned k;
    if (sel == 0) begin
      k = a % (4 * DEPTH_A);
      return mem_a[k];
    end else begin
      k = a % (4 * DEPTH_B);
      return mem_b[k];
    end
  endfunction

  task automatic put_byte(input int sel, input logic [31:0] a, input logic [7:0] v);
    int unsigned k;
    if (sel == 0) begin
      k = a % (4 * DEPTH_A);
      mem_a[k] = v;
    end else begin
      k = a % (4 * DEPTH_B);
      mem_b[k] = v;
    end
  endtask

  // an access of 2**s bytes must start on a multiple of 2**s; size 3 never legal
  function automatic logic faulty(input logic [1:0] s, input logic [31:0] a);
    return (s == SZ_X) || ((a % (32'd1 << s)) != 32'd0);
  endfunction

  function automatic logic [31:0] ref_load(input int sel, input logic [1:0] s, input logic u,
                                           input logic [31:0] a);
    logic [31:0] v;
    int n;
    v = 32'd0;
    n = 1 << s;
    for (int i = 0; i < n; i++) v = v | ({24'd0, get_byte(sel, a + i)} << (8 * i));
    if (!u && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  // one full transaction on instance sel, checked cycle by cycle
  task automatic access(input int sel, input logic w, input logic [1:0] s, input logic u,
                        input logic [31:0] a, input logic [31:0] wd, output logic [31:0] obs);
    int          lat;
    logic        exp_m, tohost;
    logic [31:0] exp_d;
    lat    = (sel == 0) ? int'(LAT_A) : int'(LAT_B);
    exp_m  = faulty(s, a);
    tohost = w && !exp_m && (s == SZ_W) && (a == TOHOST);
    exp_d  = (w || exp_m) ? 32'd0 : ref_load(sel, s, u, a);
    @(negedge clk);
    chk("ready_idle", {31'd0, rdy[sel]}, 32'd1);
    we = w; size = s; uns = u; addr = a; wdata = wd; pc = $urandom;
    req_valid[sel] = 1'b1;
    @(posedge clk);
    #1 req_valid[sel] = 1'b0;
    if (!exp_m && tohost) begin
      halt_m[sel] = 1'b1;
      exit_m[sel] = wd;
    end else if (!exp_m && w) begin
      for (int i = 0; i < (1 << s); i++) put_byte(sel, a + i, wd[8*i +: 8]);
    end
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      chk("rsp_valid", {31'd0, rspv[sel]}, {31'd0, k == lat});
      chk("ready_busy", {31'd0, rdy[sel]}, {31'd0, (k == lat + 1) && !halt_m[sel]});
      if (k >= lat) begin
        chk("rsp_data", rdat[sel], exp_d);
        chk("rsp_mis", {31'd0, mis[sel]}, {31'd0, exp_m});
        chk("halted", {31'd0, halt[sel]}, {31'd0, halt_m[sel]});
        chk("exit_code", exitc[sel], exit_m[sel]);
      end
    end
    obs = rdat[sel];
  endtask

  task automatic rand_access(input int sel);
    logic [1:0]  s;
    logic [31:0] a;
    logic [31:0] d;
    s = 2'($urandom_range(0, 3));
    a = $urandom;
    if ($urandom_range(0, 3) != 0) a = a & 32'h0000_00FF;
    if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << s) - 32'd1);
    if (a == TOHOST) a = 32'd0;
    access(sel, 1'($urandom_range(0, 1)), s, 1'($urandom_range(0, 1)), a, $urandom, d);
  endtask

  task automatic chk_reset_outputs(input int sel);
    chk("rst_ready", {31'd0, rdy[sel]}, 32'd1);
    chk("rst_rsp", {31'd0, rspv[sel]}, 32'd0);
    chk("rst_data", rdat[sel], 32'd0);
    chk("rst_mis", {31'd0, mis[sel]}, 32'd0);
    chk("rst_halted", {31'd0, halt[sel]}, 32'd0);
    chk("rst_exit", exitc[sel], 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    rstn = 1'b1; req_valid = 2'b00; we = 1'b0; size = SZ_B; uns = 1'b0;
    addr = 32'd0; wdata = 32'd0; pc = 32'd0;
    model_clear();
    #2 rstn = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs(0);
    chk_reset_outputs(1);
    rstn = 1'b1;

    // directed word/byte/half behaviour on the LATENCY 1 instance
    access(0, 1'b1, SZ_W, 1'b0, 32'h10, 32'hDEAD_BEEF, d);
    access(0, 1'b0, SZ_W, 1'b0, 32'h10, 32'd0, d);        chk("lw_deadbeef", d, 32'hDEAD_BEEF);
    access(0, 1'b1, SZ_W, 1'b0, 32'h10, 32'd0, d);
    access(0, 1'b1, SZ_B, 1'b0, 32'h13, 32'h0000_0080, d);
    access(0, 1'b0, SZ_B, 1'b0, 32'h13, 32'd0, d);        chk("lb_sext", d, 32'hFFFF_FF80);
    access(0, 1'b0, SZ_B, 1'b1, 32'h13, 32'd0, d);        chk("lbu_zext", d, 32'h0000_0080);
    access(0, 1'b0, SZ_W, 1'b0, 32'h10, 32'd0, d);        chk("lw_after_sb", d, 32'h8000_0000);
    access(0, 1'b1, SZ_H, 1'b0, 32'h22, 32'h0000_1234, d);
    access(0, 1'b0, SZ_H, 1'b0, 32'h21, 32'd0, d);        chk("lh_mis_data", d, 32'd0);
    chk("lh_mis_flag", {31'd0, mis[0]}, 32'd1);
    access(0, 1'b0, SZ_W, 1'b0, 32'h20, 32'd0, d);        chk("lw_after_sh", d, 32'h1234_0000);
    access(0, 1'b1, SZ_W, 1'b0, 32'h22, 32'hFFFF_FFFF, d);
    access(0, 1'b1, SZ_X, 1'b0, 32'h20, 32'hFFFF_FFFF, d);
    access(0, 1'b0, SZ_W, 1'b0, 32'h20, 32'd0, d);        chk("fault_no_write", d, 32'h1234_0000);
    access(0, 1'b1, SZ_H, 1'b0, 32'h20, 32'h0000_8001, d);
    access(0, 1'b0, SZ_H, 1'b0, 32'h20, 32'd0, d);        chk("lh_sext", d, 32'hFFFF_8001);
    access(0, 1'b0, SZ_H, 1'b1, 32'h20, 32'd0, d);        chk("lhu_zext", d, 32'h0000_8001);

    for (int n = 0; n < 60; n++) rand_access(0);

    // LATENCY 3 instance: timing profile is checked inside access()
    access(1, 1'b1, SZ_W, 1'b0, 32'h10, 32'h5A5A_5A5A, d);
    access(1, 1'b0, SZ_W, 1'b0, 32'h10, 32'd0, d);        chk("b_lw", d, 32'h5A5A_5A5A);
    for (int n = 0; n < 30; n++) rand_access(1);
    access(1, 1'b0, SZ_W, 1'b0, 32'h10, 32'd0, d);        chk("b_lw_nonzero", d, 32'h5A5A_5A5A);

    // reset asserted while the LATENCY 3 instance is waiting
    @(negedge clk);
    we = 1'b0; size = SZ_W; uns = 1'b0; addr = 32'h10;
    req_valid[1] = 1'b1;
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    @(negedge clk);
    chk("wait_no_rsp", {31'd0, rspv[1]}, 32'd0);
    rstn = 1'b0;
    model_clear();
    #1 chk_reset_outputs(1);
    chk_reset_outputs(0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("no_stale_rsp", {31'd0, rspv[1]}, 32'd0);
    end
    access(1, 1'b0, SZ_W, 1'b0, 32'h10, 32'd0, d);        chk("lw_after_reset", d, 32'd0);

    // byte store to the tohost address is an ordinary memory access
    access(1, 1'b1, SZ_B, 1'b0, TOHOST, 32'h0000_0077, d);
    access(1, 1'b0, SZ_W, 1'b0, 32'h0, 32'd0, d);         chk("tohost_sb_mem", d, 32'h0000_0077);
    chk("b_not_halted", {31'd0, halt[1]}, 32'd0);

    // address wrap on the 16-word instance
    access(0, 1'b1, SZ_W, 1'b0, 32'h40, 32'h0000_00A5, d);
    access(0, 1'b0, SZ_W, 1'b0, 32'h0, 32'd0, d);         chk("wrap_lw", d, 32'h0000_00A5);

    // tohost halt: response still pulses, ready stays low, no further accept
    access(0, 1'b1, SZ_W, 1'b0, TOHOST, 32'd1, d);
    chk("halt_set", {31'd0, halt[0]}, 32'd1);
    chk("halt_exit", exitc[0], 32'd1);
    @(negedge clk);
    we = 1'b0; size = SZ_W; addr = 32'h0;
    req_valid[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("halt_ready", {31'd0, rdy[0]}, 32'd0);
      chk("halt_no_rsp", {31'd0, rspv[0]}, 32'd0);
    end
    req_valid[0] = 1'b0;
    chk("b_ready_free", {31'd0, rdy[1]}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
